// File: rtl/mem_port_responder.sv
// -----------------------------------------------------------------------------
// mem_port_responder
//   Responder end of the accelerator memory request/response interface.
//   Requests are served from a local SRAM of 2^AW 64-bit words. Every accepted
//   request produces exactly one response, in request order, LATENCY cycles
//   after the accept edge. Responses have no back-pressure.
//
//   Parameters
//     AW          word-address bits (capacity 2^AW x 64-bit words)
//     LATENCY     accept edge to response-valid cycle, >= 1
//     STALL_EVERY ready drops for one cycle after this many accepts (0 = never)
//     NACK_EVERY  every NACK_EVERY-th accept is refused (nack build only)
//
//   Build option
//     MEM_RESP_NACK_EN  when defined, every NACK_EVERY-th accept is nacked:
//                       no memory effect, has_data = 0, data = 0.
//
//   Ports
//     clk, reset                 clock, asynchronous active-high reset
//     io_mem_req_*               request channel (valid/ready handshake)
//     io_mem_invalidate_lr       ignored
//     io_mem_resp_*              response channel (valid only)
// -----------------------------------------------------------------------------
module mem_port_responder #(
  parameter int AW          = 10,
  parameter int LATENCY     = 2,
  parameter int STALL_EVERY = 0,
  parameter int NACK_EVERY  = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        io_mem_req_ready,
  input  logic        io_mem_req_valid,
  input  logic [39:0] io_mem_req_bits_addr,
  input  logic [9:0]  io_mem_req_bits_tag,
  input  logic [4:0]  io_mem_req_bits_cmd,
  input  logic [2:0]  io_mem_req_bits_typ,
  input  logic        io_mem_req_bits_phys,
  input  logic [63:0] io_mem_req_bits_data,
  input  logic        io_mem_invalidate_lr,
  output logic        io_mem_resp_valid,
  output logic [39:0] io_mem_resp_bits_addr,
  output logic [9:0]  io_mem_resp_bits_tag,
  output logic [4:0]  io_mem_resp_bits_cmd,
  output logic [2:0]  io_mem_resp_bits_typ,
  output logic [63:0] io_mem_resp_bits_data,
  output logic        io_mem_resp_bits_nack,
  output logic        io_mem_resp_bits_replay,
  output logic        io_mem_resp_bits_has_data,
  output logic [63:0] io_mem_resp_bits_data_word_bypass,
  output logic [63:0] io_mem_resp_bits_store_data
);

  typedef struct packed {
    logic [39:0] addr;
    logic [9:0]  tag;
    logic [4:0]  cmd;
    logic [2:0]  typ;
    logic [63:0] data;
    logic        nack;
    logic        has_data;
    logic [63:0] bypass;
    logic [63:0] store_data;
  } resp_t;

  localparam int SW = (STALL_EVERY > 1) ? $clog2(STALL_EVERY + 1) : 1;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0f;
      default: return 8'hff;
    endcase
  endfunction

  // Misaligned low address bits are dropped, so an access never crosses a word.
  function automatic logic [2:0] align_lane(input logic [2:0] a, input logic [1:0] size);
    case (size)
      2'd0:    return a;
      2'd1:    return {a[2:1], 1'b0};
      2'd2:    return {a[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [63:0] extend_load(input logic [63:0] word, input logic [2:0] lane,
                                              input logic [1:0] size, input logic zext);
    logic [63:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      2'd0:    return zext ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    return zext ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    return zext ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  logic [63:0]   mem [2**AW];
  logic          accept, is_load, is_store, nack_now, do_store, ld_ok, stall_hit;
  logic [1:0]    size;
  logic [2:0]    lane;
  logic [AW-1:0] widx;
  logic [63:0]   rd_word, wdata;
  logic [7:0]    be;
  logic [SW-1:0] stall_cnt;
  logic          ready_q;
  resp_t         stage_in, resp_out;
  resp_t         data_p [LATENCY];
  logic [LATENCY-1:0] vld_p;
  logic          unused_inputs;

  assign unused_inputs = io_mem_req_bits_phys ^ io_mem_invalidate_lr;

  assign io_mem_req_ready = ready_q;
  assign accept   = io_mem_req_valid & ready_q;
  assign is_load  = (io_mem_req_bits_cmd == 5'd0);
  assign is_store = (io_mem_req_bits_cmd == 5'd1);
  assign size     = io_mem_req_bits_typ[1:0];
  assign lane     = align_lane(io_mem_req_bits_addr[2:0], size);
  assign widx     = io_mem_req_bits_addr[AW+2:3];
  assign rd_word  = mem[widx];
  assign be       = size_mask(size) << lane;
  assign wdata    = io_mem_req_bits_data << {lane, 3'b000};
  assign do_store = accept & is_store & ~nack_now;
  assign ld_ok    = is_load & ~nack_now;

`ifdef MEM_RESP_NACK_EN
  localparam int NW = (NACK_EVERY > 1) ? $clog2(NACK_EVERY + 1) : 1;
  logic [NW-1:0] nack_cnt;

  // nack_cnt holds accepts seen so far in this round; the NACK_EVERY-th is refused.
  assign nack_now = accept && (nack_cnt == NW'(NACK_EVERY - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       nack_cnt <= '0;
    else if (accept) nack_cnt <= nack_now ? '0 : nack_cnt + 1'b1;
  end
`else
  logic unused_cfg;
  assign unused_cfg = (NACK_EVERY == 0);
  assign nack_now   = 1'b0;
`endif

  // Ready is registered: it is 0 in reset and for one cycle after each stall window.
  assign stall_hit = (STALL_EVERY != 0) && accept && (stall_cnt == SW'(STALL_EVERY - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= ~stall_hit;
      if (accept && (STALL_EVERY != 0)) stall_cnt <= stall_hit ? '0 : stall_cnt + 1'b1;
    end
  end

  // SRAM contents survive reset; only accepted, non-nacked stores write.
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    stage_in            = '0;
    stage_in.addr       = io_mem_req_bits_addr;
    stage_in.tag        = io_mem_req_bits_tag;
    stage_in.cmd        = io_mem_req_bits_cmd;
    stage_in.typ        = io_mem_req_bits_typ;
    stage_in.nack       = nack_now;
    stage_in.has_data   = ld_ok;
    stage_in.data       = ld_ok ? extend_load(rd_word, lane, size, io_mem_req_bits_typ[2]) : 64'd0;
    stage_in.bypass     = ld_ok ? rd_word : 64'd0;
    stage_in.store_data = (is_store & ~nack_now) ? io_mem_req_bits_data : 64'd0;
  end

  // Stage p0: capture of the accepted request; later stages are a plain delay line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    data_p[0] <= stage_in;
    for (int i = 1; i < LATENCY; i++) data_p[i] <= data_p[i-1];
  end

  // Response stage: fields are forced to 0 whenever no response is valid,
  // which also clears them immediately on reset.
  assign resp_out = vld_p[LATENCY-1] ? data_p[LATENCY-1] : '0;

  assign io_mem_resp_valid                 = vld_p[LATENCY-1];
  assign io_mem_resp_bits_addr             = resp_out.addr;
  assign io_mem_resp_bits_tag              = resp_out.tag;
  assign io_mem_resp_bits_cmd              = resp_out.cmd;
  assign io_mem_resp_bits_typ              = resp_out.typ;
  assign io_mem_resp_bits_data             = resp_out.data;
  assign io_mem_resp_bits_nack             = resp_out.nack;
  assign io_mem_resp_bits_replay           = 1'b0;
  assign io_mem_resp_bits_has_data         = resp_out.has_data;
  assign io_mem_resp_bits_data_word_bypass = resp_out.bypass;
  assign io_mem_resp_bits_store_data       = resp_out.store_data;

endmodule

// File: tb/tb_mem_port_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_port_responder
//   Bench for mem_port_responder (STALL_EVERY = 3, LATENCY = 2). A byte-array
//   memory model and a queue of timestamped expected responses predict ready,
//   resp_valid and every response field each cycle. Build with
//   MEM_RESP_NACK_EN defined to exercise the nack variant.
// -----------------------------------------------------------------------------
module tb_mem_port_responder;
  localparam int AW  = 10;
  localparam int LAT = 2;
  localparam int SE  = 3;
  localparam int NE  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_ready, req_valid, req_phys, inv_lr;
  logic [39:0] req_addr;
  logic [9:0]  req_tag;
  logic [4:0]  req_cmd;
  logic [2:0]  req_typ;
  logic [63:0] req_data;
  logic        resp_valid, resp_nack, resp_replay, resp_has_data;
  logic [39:0] resp_addr;
  logic [9:0]  resp_tag;
  logic [4:0]  resp_cmd;
  logic [2:0]  resp_typ;
  logic [63:0] resp_data, resp_bypass, resp_store_data;

  always #5 clk = ~clk;

  mem_port_responder #(.AW(AW), .LATENCY(LAT), .STALL_EVERY(SE), .NACK_EVERY(NE)) dut (
    .clk(clk), .reset(reset),
    .io_mem_req_ready(req_ready), .io_mem_req_valid(req_valid),
    .io_mem_req_bits_addr(req_addr), .io_mem_req_bits_tag(req_tag),
    .io_mem_req_bits_cmd(req_cmd), .io_mem_req_bits_typ(req_typ),
    .io_mem_req_bits_phys(req_phys), .io_mem_req_bits_data(req_data),
    .io_mem_invalidate_lr(inv_lr),
    .io_mem_resp_valid(resp_valid), .io_mem_resp_bits_addr(resp_addr),
    .io_mem_resp_bits_tag(resp_tag), .io_mem_resp_bits_cmd(resp_cmd),
    .io_mem_resp_bits_typ(resp_typ), .io_mem_resp_bits_data(resp_data),
    .io_mem_resp_bits_nack(resp_nack), .io_mem_resp_bits_replay(resp_replay),
    .io_mem_resp_bits_has_data(resp_has_data),
    .io_mem_resp_bits_data_word_bypass(resp_bypass),
    .io_mem_resp_bits_store_data(resp_store_data)
  );

  typedef struct {
    int          due;
    logic [39:0] addr;
    logic [9:0]  tag;
    logic [4:0]  cmd;
    logic [2:0]  typ;
    logic [63:0] data;
    logic        nack;
    logic        has;
    logic [63:0] byp;
    logic [63:0] sd;
  } exp_t;

  logic [7:0] mm [128];   // bytes of words 0..15, the only words the bench touches
  exp_t q[$];
  int   e = 0;            // posedges seen
  bit   alive = 1'b0, blk = 1'b0;
  int   scnt = 0, ncnt = 0;
  int   n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [39:0] mkaddr(input int w, input int l);
    logic [39:0] a;
    a = {8'($urandom), 32'($urandom)};
    a[12:7] = '0;
    a[6:3]  = 4'(w);
    a[2:0]  = 3'(l);
    return a;
  endfunction

  task automatic check_outputs();
    exp_t x;
    check("req_ready", 64'(req_ready), 64'(alive && !blk));
    if (q.size() > 0 && q[0].due == e) begin
      x = q.pop_front();
      check("resp_valid", 64'(resp_valid), 64'd1);
      check("resp_tag", 64'(resp_tag), 64'(x.tag));
      check("resp_addr", 64'(resp_addr), 64'(x.addr));
      check("resp_cmd", 64'(resp_cmd), 64'(x.cmd));
      check("resp_typ", 64'(resp_typ), 64'(x.typ));
      check("resp_data", resp_data, x.data);
      check("resp_nack", 64'(resp_nack), 64'(x.nack));
      check("resp_replay", 64'(resp_replay), 64'd0);
      check("resp_has_data", 64'(resp_has_data), 64'(x.has));
      check("resp_bypass", resp_bypass, x.byp);
      check("resp_store_data", resp_store_data, x.sd);
    end else begin
      check("resp_valid", 64'(resp_valid), 64'd0);
    end
  endtask

  // Behavioural effect of one accepted request on the model.
  task automatic model_accept(input logic [39:0] a, input logic [9:0] t, input logic [4:0] c,
                              input logic [2:0] ty, input logic [63:0] d, output bit nk);
    exp_t x;
    int n, lane, base;
    logic [63:0] word, val;
    n    = 1 << int'(ty[1:0]);
    lane = int'(a[2:0]) & ~(n - 1);
    base = int'(a[6:3]) * 8;
    nk   = 1'b0;
`ifdef MEM_RESP_NACK_EN
    ncnt++;
    if (ncnt == NE) begin nk = 1'b1; ncnt = 0; end
`endif
    word = '0;
    for (int i = 0; i < 8; i++) word[8*i +: 8] = mm[base + i];
    x.due = e + LAT; x.addr = a; x.tag = t; x.cmd = c; x.typ = ty; x.nack = nk;
    x.has = 1'b0; x.data = '0; x.byp = '0; x.sd = '0;
    if (c == 5'd0 && !nk) begin
      val = '0;
      for (int i = 0; i < n; i++) val[8*i +: 8] = mm[base + lane + i];
      if (!ty[2] && n < 8 && val[8*n-1]) val = val | ~((64'd1 << (8*n)) - 64'd1);
      x.has = 1'b1; x.data = val; x.byp = word;
    end
    if (c == 5'd1 && !nk) begin
      x.sd = d;
      for (int i = 0; i < n; i++) mm[base + lane + i] = d[8*i +: 8];
    end
    q.push_back(x);
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model over the edge.
  task automatic cycle(input bit v, input logic [39:0] a, input logic [9:0] t, input logic [4:0] c,
                       input logic [2:0] ty, input logic [63:0] d,
                       output bit acc, output bit nk, output bit dacc);
    bit nb;
    check_outputs();
    req_valid = v; req_addr = a; req_tag = t; req_cmd = c; req_typ = ty; req_data = d;
    req_phys = 1'($urandom); inv_lr = 1'($urandom);
    dacc = v && req_ready;
    acc  = v && alive && !blk;
    nk = 1'b0; nb = 1'b0;
    if (acc) begin
      model_accept(a, t, c, ty, d, nk);
      scnt++;
      if (scnt == SE) begin nb = 1'b1; scnt = 0; end
    end
    @(posedge clk);
    e++; alive = 1'b1; blk = nb;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a0, n0, d0;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, '0, '0, a0, n0, d0);
  endtask

  task automatic req(input logic [39:0] a, input logic [9:0] t, input logic [4:0] c,
                     input logic [2:0] ty, input logic [63:0] d, output bit nk);
    bit acc, dacc;
    int n;
    n = 0;
    do begin
      cycle(1'b1, a, t, c, ty, d, acc, nk, dacc);
      n++;
    end while (!acc && n < 10);
    check("accepted", 64'(dacc), 64'd1);
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_tag", 64'(resp_tag), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_resp_bypass", resp_bypass, 64'd0);
    check("rst_resp_flags", 64'({resp_has_data, resp_nack, resp_replay}), 64'd0);
    q.delete(); alive = 1'b0; blk = 1'b0; scnt = 0; ncnt = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit nk, acc, dacc;
    int tries, nacc, ncyc, r;
    logic [4:0] c;
    req_valid = 0; req_addr = '0; req_tag = '0; req_cmd = '0; req_typ = '0;
    req_data = '0; req_phys = 0; inv_lr = 0;

    do_reset();

    // Give every model word a known value so loads never read uninitialised SRAM.
    for (int w = 0; w < 16; w++) begin
      tries = 0;
      do begin
        req(mkaddr(w, 0), 10'(w), 5'd1, 3'd3, {$urandom, $urandom}, nk);
        tries++;
      end while (nk && tries < 4);
    end
    idle(3);

    // Doubleword store/load, byte store, signed/unsigned byte loads.
    req(40'h40, 10'd5, 5'd1, 3'd3, 64'h1122334455667788, nk);
    req(40'h40, 10'd6, 5'd0, 3'd3, 64'd0, nk);
    req(40'h41, 10'd7, 5'd1, 3'd0, 64'h80, nk);
    req(40'h41, 10'd8, 5'd0, 3'd0, 64'd0, nk);
    req(40'h41, 10'd9, 5'd0, 3'd4, 64'd0, nk);
    req(40'h47, 10'd10, 5'd0, 3'd0, 64'd0, nk);
    req(40'h44, 10'd11, 5'd0, 3'd1, 64'd0, nk);
    req(40'h43, 10'd12, 5'd7, 3'd2, 64'hdead, nk);
    idle(4);

    // Burst of eight loads with valid held; responses must keep tag order.
    for (int i = 0; i < 8; i++) req(mkaddr(i, i), 10'(i), 5'd0, 3'($urandom), 64'd0, nk);
    idle(4);

    // Reset while two loads are in flight.
    req(mkaddr(1, 0), 10'd100, 5'd0, 3'd3, 64'd0, nk);
    req(mkaddr(2, 0), 10'd101, 5'd0, 3'd3, 64'd0, nk);
    check("pre_rst_valid", 64'(resp_valid), 64'(q.size() > 0 && q[0].due == e));
    do_reset();
    idle(1);

    // Stall pattern straight after reset: 9 accepts take 11 cycles.
    nacc = 0; ncyc = 0;
    while (nacc < 9 && ncyc < 30) begin
      cycle(1'b1, mkaddr(ncyc % 16, 0), 10'(200 + ncyc), 5'd0, 3'd3, 64'd0, acc, nk, dacc);
      ncyc++;
      if (dacc) nacc++;
    end
    check("stall_accepts", 64'(nacc), 64'd9);
    check("stall_cycles", 64'(ncyc), 64'd11);
    idle(4);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 19));
      c = (r < 9) ? 5'd0 : (r < 18) ? 5'd1 : 5'($urandom_range(2, 31));
      cycle(($urandom_range(0, 3) != 0), mkaddr(int'($urandom_range(0, 15)), int'($urandom_range(0, 7))),
            10'($urandom), c, 3'($urandom), {$urandom, $urandom}, acc, nk, dacc);
    end
    idle(4);

`ifdef MEM_RESP_NACK_EN
    // Fourth accept after reset is refused, so the load sees the third store.
    do_reset();
    idle(1);
    for (int i = 1; i <= 4; i++) req(40'h0, 10'(300 + i), 5'd1, 3'd3, 64'(i), nk);
    req(40'h0, 10'd305, 5'd0, 3'd3, 64'd0, nk);
    idle(4);
`endif

    idle(2);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
